// File: rtl/fpadd_stream_ctrl.sv
// Valid/ready stream wrapper around a fixed-latency, non-stalling FP adder datapath.
// Define FPADD_STREAM_FLAGS_EN to add per-entry out_flags {inf_or_nan, zero}.
module fpadd_stream_ctrl #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] bus_a,
    output logic [31:0] bus_b,
    input  logic [31:0] bus_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
`ifdef FPADD_STREAM_FLAGS_EN
    output logic [1:0]  out_flags,
`endif
    output logic        busy
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic               in_fire;
    logic               out_fire;
    logic               capture;
    logic [31:0]        bus_a_q, bus_a_d;
    logic [31:0]        bus_b_q, bus_b_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CntW-1:0]    used_q, used_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [PtrW-1:0]    head_q, head_d;
    logic [PtrW-1:0]    tail_q, tail_d;
    logic [31:0]        mem_q [DEPTH];
`ifdef FPADD_STREAM_FLAGS_EN
    logic [1:0]         flag_q [DEPTH];
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Credits are counted from issue to pop, so in-flight ops always have a FIFO slot.
    assign in_ready   = (used_q < DepthC);
    assign out_valid  = (count_q != '0);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign capture    = vld_q[LATENCY-1];
    assign busy       = (used_q != '0);
    assign bus_a      = bus_a_q;
    assign bus_b      = bus_b_q;
    assign out_result = out_valid ? mem_q[head_q] : '0;
`ifdef FPADD_STREAM_FLAGS_EN
    assign out_flags  = out_valid ? flag_q[head_q] : 2'b00;
`endif

    always_comb begin
        bus_a_d = bus_a_q;
        bus_b_d = bus_b_q;
        if (in_fire) begin
            bus_a_d = in_a;
            bus_b_d = in_b;
        end

        vld_d    = '0;
        vld_d[0] = in_fire;
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
        end

        unique case ({in_fire, out_fire})
            2'b10:   used_d = used_q + CntW'(1);
            2'b01:   used_d = used_q - CntW'(1);
            default: used_d = used_q;
        endcase

        unique case ({capture, out_fire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        head_d = out_fire ? ptr_inc(head_q) : head_q;
        tail_d = capture  ? ptr_inc(tail_q) : tail_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_a_q <= '0;
            bus_b_q <= '0;
            vld_q   <= '0;
            used_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            bus_a_q <= bus_a_d;
            bus_b_q <= bus_b_d;
            vld_q   <= vld_d;
            used_q  <= used_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[tail_q] <= bus_result;
`ifdef FPADD_STREAM_FLAGS_EN
            flag_q[tail_q] <= {bus_result[30:23] == 8'hFF, bus_result[30:0] == 31'd0};
`endif
        end
    end

`ifndef SYNTHESIS
    if (LATENCY < 1 || DEPTH < 2) begin : g_param_check
        $error("fpadd_stream_ctrl: LATENCY must be >= 1 and DEPTH >= 2");
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        capture |-> (count_q != DepthC))
        else $error("fpadd_stream_ctrl: capture into full FIFO");

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(out_result))
        else $error("fpadd_stream_ctrl: out_result changed while stalled");
`endif

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// Self-checking bench for fpadd_stream_ctrl: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fpadd_stream_ctrl;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic        raw_mode  = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [31:0] bus_a, bus_b, bus_result, out_result;
`ifdef FPADD_STREAM_FLAGS_EN
    logic [1:0]  out_flags;
`endif
    logic [31:0] dp [LATENCY-1];

    int n_checks = 0;
    int n_errs   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    fpadd_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .bus_result(bus_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
`ifdef FPADD_STREAM_FLAGS_EN
        .out_flags (out_flags),
`endif
        .busy      (busy)
    );

    // Reference adder stub for normal operands, via double precision.
    function automatic logic [63:0] s2d(input logic [31:0] s);
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        e = d[62:52];
        if (e <= 11'd896) return {d[63], 31'd0};
        if (e >= 11'd1151) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(b));
        return d2s($realtobits(ra + rb));
    endfunction

    function automatic logic [1:0] flags_of(input logic [31:0] r);
        return {r[30:23] == 8'hFF, r[30:0] == 31'd0};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // Datapath stand-in: LATENCY-1 register stages between bus_a/bus_b and bus_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY - 1; i++) dp[i] <= '0;
        end else begin
            dp[0] <= raw_mode ? bus_a : fadd(bus_a, bus_b);
            for (int i = 1; i < LATENCY - 1; i++) dp[i] <= dp[i-1];
        end
    end
    assign bus_result = dp[LATENCY-2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: ops carry a due edge; results move to an unbounded queue when due.
    logic [31:0] m_fifo[$];
    logic [31:0] m_fly[$];
    longint      m_due[$];
    longint      m_cyc   = 0;
    int          m_used  = 0;
    logic [31:0] m_bus_a = '0;
    logic [31:0] m_bus_b = '0;

    task automatic model_clear();
        m_fifo.delete();
        m_fly.delete();
        m_due.delete();
        m_used  = 0;
        m_bus_a = '0;
        m_bus_b = '0;
    endtask

    task automatic model_step();
        bit f, p;
        m_cyc++;
        f = in_valid && (m_used < int'(DEPTH));
        p = out_ready && (m_fifo.size() != 0);
        if (p) void'(m_fifo.pop_front());
        if (f) begin
            m_fly.push_back(raw_mode ? in_a : fadd(in_a, in_b));
            m_due.push_back(m_cyc + longint'(LATENCY));
            m_bus_a = in_a;
            m_bus_b = in_b;
        end
        m_used = m_used + int'(f) - int'(p);
        while (m_due.size() != 0 && m_due[0] == m_cyc) begin
            m_fifo.push_back(m_fly.pop_front());
            void'(m_due.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n) model_step();
    end

    initial forever begin
        @(negedge rst_n);
        model_clear();
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("mon_in_ready", 32'(in_ready), 32'(m_used < int'(DEPTH)));
            chk("mon_out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
            chk("mon_out_result", out_result, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
            chk("mon_busy", 32'(busy), 32'(m_used != 0));
            chk("mon_bus_a", bus_a, m_bus_a);
            chk("mon_bus_b", bus_b, m_bus_b);
`ifdef FPADD_STREAM_FLAGS_EN
            chk("mon_flags", 32'(out_flags),
                32'((m_fifo.size() != 0) ? flags_of(m_fifo[0]) : 2'b00));
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [1:0]  flags;
    } fvec_t;

    vec_t  vecs [5];
    fvec_t fvecs [4];

    initial begin
        int   n, fires, seen, last_k, drops, stale;
        logic fired;

        vecs[0] = '{a: 32'h3F800000, b: 32'h40000000, exp: 32'h40400000};
        vecs[1] = '{a: 32'h40000000, b: 32'h40000000, exp: 32'h40800000};
        vecs[2] = '{a: 32'h3FC00000, b: 32'h3F000000, exp: 32'h40000000};
        vecs[3] = '{a: 32'hBF800000, b: 32'h3F800000, exp: 32'h00000000};
        vecs[4] = '{a: 32'h40400000, b: 32'hBF800000, exp: 32'h40000000};
        fvecs[0] = '{r: 32'h7F800000, flags: 2'b10};
        fvecs[1] = '{r: 32'h7FC00000, flags: 2'b10};
        fvecs[2] = '{r: 32'h80000000, flags: 2'b01};
        fvecs[3] = '{r: 32'h3F800000, flags: 2'b00};

        model_clear();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state, held and after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_a", bus_a, 32'd0);
        chk("rst_bus_b", bus_b, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // Isolated ops: latency, result, busy lifetime
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("vec_bus_a", bus_a, vecs[i].a);
            chk("vec_bus_b", bus_b, vecs[i].b);
            n = 0;
            while (!out_valid && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("vec_latency", 32'(n), 32'(LATENCY));
            chk("vec_result", out_result, vecs[i].exp);
            chk("vec_busy_held", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            chk("vec_busy_drop", 32'(busy), 32'd0);
            chk("vec_valid_drop", 32'(out_valid), 32'd0);
        end

        // Fill with consumer stalled: exactly DEPTH admissions
        out_ready = 1'b0;
        fires     = 0;
        for (int i = 0; i < int'(DEPTH) + 4; i++) begin
            in_valid = 1'b1;
            in_a     = {1'b0, 8'(127 + fires), 23'd0};
            in_b     = 32'h3F800000;
            if (in_ready) fires++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("fill_fires", 32'(fires), 32'(DEPTH));
        chk("fill_ready_low", 32'(in_ready), 32'd0);
        repeat (LATENCY) @(posedge clk);
        #1;
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_first", out_result, fadd(32'h3F800000, 32'h3F800000));
        chk("fill_ready_still_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fill_ready_after_pop", 32'(in_ready), 32'd1);
        chk("fill_second", out_result, fadd(32'h40000000, 32'h3F800000));
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        chk("fill_drained_busy", 32'(busy), 32'd0);

        // Back-to-back stream with consumer always ready
        seen   = 0;
        last_k = -1;
        drops  = 0;
        for (int k = 0; k < 16 + int'(LATENCY) + 4; k++) begin
            in_valid = (k < 16);
            in_a     = rnd_fp();
            in_b     = rnd_fp();
            if (in_valid && !in_ready) drops++;
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen++;
                last_k = k;
            end
        end
        in_valid = 1'b0;
        chk("b2b_ready_drops", 32'(drops), 32'd0);
        chk("b2b_results", 32'(seen), 32'd16);
        chk("b2b_last_edge", 32'(last_k), 32'(15 + LATENCY));

        // Reset with 2 queued and 3 in flight
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a     = rnd_fp();
            in_b     = rnd_fp();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_queued_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(out_valid), 32'd0);
        chk("mid_async_busy", 32'(busy), 32'd0);
        chk("mid_async_ready", 32'(in_ready), 32'd1);
        chk("mid_async_result", out_result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        chk("mid_no_stale", 32'(stale), 32'd0);

`ifdef FPADD_STREAM_FLAGS_EN
        raw_mode  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = fvecs[i].r;
            in_b     = 32'd0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("flag_result", out_result, fvecs[i].r);
            chk("flag_bits", 32'(out_flags), 32'(fvecs[i].flags));
            @(posedge clk);
            #1;
        end
        raw_mode = 1'b0;
`endif

        // Randomized traffic with periodic consumer stalls
        fired = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (!in_valid || fired) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = rnd_fp();
                in_b     = rnd_fp();
            end
            out_ready = ((k % 64) < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
            fired     = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + LATENCY + 4) @(posedge clk);
        #1;
        chk("rand_drain_busy", 32'(busy), 32'd0);
        chk("rand_drain_valid", 32'(out_valid), 32'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
